// File: rtl/cpu_defs.sv
// Shared opcode constants and opcode-class decode for the execute and fetch control.
package cpu_defs;

  localparam logic [3:0] i_load     = 4'd0;
  localparam logic [3:0] i_stop     = 4'd1;
  localparam logic [3:0] i_store    = 4'd2;
  localparam logic [3:0] i_add      = 4'd4;
  localparam logic [3:0] i_bz       = 4'd5;
  localparam logic [3:0] i_subtract = 4'd6;
  localparam logic [3:0] i_nand     = 4'd8;
  localparam logic [3:0] i_bnz      = 4'd9;
  localparam logic [3:0] i_nop      = 4'd10;
  localparam logic [3:0] i_bpz      = 4'd13;

  // shift and ori are decoded on the low three bits only
  localparam logic [2:0] i_shift    = 3'd3;
  localparam logic [2:0] i_ori      = 3'd7;

  // Exact 4-bit opcodes win; only unmatched codes fall back to the 3-bit shift/ori match.
  function automatic logic is_alu(input logic [3:0] op);
    logic r;
    case (op)
      i_add, i_subtract, i_nand:                               r = 1'b1;
      i_load, i_stop, i_store, i_bz, i_bnz, i_nop, i_bpz:      r = 1'b0;
      default:                                                 r = (op[2:0] == i_shift) || (op[2:0] == i_ori);
    endcase
    return r;
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == i_bz) || (op == i_bnz) || (op == i_bpz);
  endfunction

  function automatic logic is_stop(input logic [3:0] op);
    return (op == i_stop);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluation against the architectural flags.
module branch_cond_eval
  import cpu_defs::*;
(
  input  logic [3:0] i_opcode,
  input  logic       i_flag_n,
  input  logic       i_flag_z,
  output logic       o_take
);

  // take is only meaningful for branch-class opcodes; other opcodes yield 0
  always_comb begin
    o_take = 1'b0;
    case (i_opcode)
      i_bz:    o_take = i_flag_z;
      i_bnz:   o_take = ~i_flag_z;
      i_bpz:   o_take = ~i_flag_n;
      default: o_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_branch.sv
// Execute-stage branch resolution: condition flags, branch decision, squash
// window for younger instructions, sticky halt and a saturating debug counter.
module control_branch
  import cpu_defs::*;
#(
  parameter int SQUASH_DEPTH = 2,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           ex_opcode,
  input  logic                 ex_valid,
  input  logic                 ex_stall,
  input  logic                 alu_n,
  input  logic                 alu_z,
  output logic                 branch,
  output logic                 ex_kill,
  output logic                 flag_n,
  output logic                 flag_z,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] branch_count
);

  // squash window never exceeds 3, so two bits suffice
  localparam logic [1:0] SQ_LOAD = 2'(SQUASH_DEPTH);

  logic                 r_flag_n;
  logic                 r_flag_z;
  logic                 r_halted;
  logic [1:0]           r_squash_cnt;
  logic [CNT_WIDTH-1:0] r_branch_count;

  logic w_eff;
  logic w_take;
  logic w_branch;
  logic w_alu;
  logic w_is_br;
  logic w_stop;

  branch_cond_eval u_cond (
    .i_opcode (ex_opcode),
    .i_flag_n (r_flag_n),
    .i_flag_z (r_flag_z),
    .o_take   (w_take)
  );

  // Decode and the effective-valid qualifier; reset gating keeps both
  // outputs quiet even though the registers already read as cleared.
  always_comb begin
    w_alu    = is_alu(ex_opcode);
    w_is_br  = is_branch(ex_opcode);
    w_stop   = is_stop(ex_opcode);
    w_eff    = ex_valid & ~r_halted & (r_squash_cnt == 2'd0);
    w_branch = ~reset & w_eff & ~ex_stall & w_is_br & w_take;
  end

  assign branch       = w_branch;
  assign ex_kill      = ~reset & ex_valid & ~w_eff;
  assign flag_n       = r_flag_n;
  assign flag_z       = r_flag_z;
  assign halted       = r_halted;
  assign branch_count = r_branch_count;

  // Architectural state; a stalled cycle leaves everything untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flag_n       <= 1'b0;
      r_flag_z       <= 1'b0;
      r_halted       <= 1'b0;
      r_squash_cnt   <= 2'd0;
      r_branch_count <= '0;
    end else if (!ex_stall) begin
      if (w_eff && w_alu) begin
        r_flag_n <= alu_n;
        r_flag_z <= alu_z;
      end
      // bubbles do not use up the squash budget
      if (w_branch)
        r_squash_cnt <= SQ_LOAD;
      else if ((r_squash_cnt != 2'd0) && ex_valid)
        r_squash_cnt <= r_squash_cnt - 2'd1;
      if (w_eff && w_stop)
        r_halted <= 1'b1;
      if (w_branch && (r_branch_count != {CNT_WIDTH{1'b1}}))
        r_branch_count <= r_branch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_control_branch.sv
module tb_control_branch;

  localparam int SQ      = 2;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    ex_opcode = 4'd10;
  logic          ex_valid = 1'b0;
  logic          ex_stall = 1'b0;
  logic          alu_n = 1'b0;
  logic          alu_z = 1'b0;
  logic          branch;
  logic          ex_kill;
  logic          flag_n;
  logic          flag_z;
  logic          halted;
  logic [CW-1:0] branch_count;

  control_branch #(.SQUASH_DEPTH(SQ), .CNT_WIDTH(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .ex_opcode    (ex_opcode),
    .ex_valid     (ex_valid),
    .ex_stall     (ex_stall),
    .alu_n        (alu_n),
    .alu_z        (alu_z),
    .branch       (branch),
    .ex_kill      (ex_kill),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .halted       (halted),
    .branch_count (branch_count)
  );

  always #5 clock = ~clock;

  int nerr = 0;
  int nchk = 0;

  // Reference model: opcode class table (0 other, 1 ALU, 2 branch, 3 stop)
  int cls [16];
  bit m_fn, m_fz, m_halt;
  int m_sq, m_cnt;
  bit p_br, p_kill, p_live, p_s, p_n, p_z, p_v;
  int p_c;
  logic obs_br, obs_kill;

  task automatic model_reset();
    m_fn = 0; m_fz = 0; m_halt = 0; m_sq = 0; m_cnt = 0;
  endtask

  task automatic model_eval(input logic [3:0] op, input logic v, s, n, z);
    bit take;
    p_c    = cls[op];
    p_live = v && !m_halt && (m_sq == 0);
    take   = (op == 4'd5 && m_fz) || (op == 4'd9 && !m_fz) || (op == 4'd13 && !m_fn);
    p_kill = v && !p_live;
    p_br   = p_live && (p_c == 2) && take && !s;
    p_s = s; p_n = n; p_z = z; p_v = v;
  endtask

  task automatic model_commit();
    if (!p_s) begin
      if (p_live && p_c == 1) begin m_fn = p_n; m_fz = p_z; end
      if (p_br) m_sq = SQ;
      else if (m_sq > 0 && p_v) m_sq = m_sq - 1;
      if (p_live && p_c == 3) m_halt = 1;
      if (p_br && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  endtask

  // One execute cycle: drive after the falling edge, sample combinational
  // outputs mid-cycle, then advance past the rising edge.
  task automatic step(input logic [3:0] op, input logic v, s, n, z);
    @(negedge clock);
    ex_opcode = op; ex_valid = v; ex_stall = s; alu_n = n; alu_z = z;
    #1;
    obs_br = branch; obs_kill = ex_kill;
    model_eval(op, v, s, n, z);
    @(posedge clock);
    #1;
    model_commit();
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; ex_valid = 1'b0; ex_stall = 1'b0; ex_opcode = 4'd10;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; ex_valid = 1'b1; ex_opcode = 4'd5; ex_stall = 1'b0;
    #2;
    nchk++; if (branch !== 1'b0) begin nerr++; $display("FAIL reset_branch got=%b exp=0", branch); end
    nchk++; if (ex_kill !== 1'b0) begin nerr++; $display("FAIL reset_kill got=%b exp=0", ex_kill); end
    nchk++; if ({flag_n, flag_z, halted} !== 3'b000) begin nerr++; $display("FAIL reset_flags got=%b exp=000", {flag_n, flag_z, halted}); end
    nchk++; if (branch_count !== '0) begin nerr++; $display("FAIL reset_count got=%0d exp=0", branch_count); end
    @(negedge clock);
    reset = 1'b0; ex_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_forwarding();
    apply_reset();
    step(4'd4, 1, 0, 0, 1);
    nchk++; if (flag_z !== 1'b1) begin nerr++; $display("FAIL fwd_flag_z got=%b exp=1", flag_z); end
    step(4'd5, 1, 0, 0, 0);
    nchk++; if (obs_br !== 1'b1) begin nerr++; $display("FAIL fwd_branch got=%b exp=1", obs_br); end
    nchk++; if (branch_count !== 8'd1) begin nerr++; $display("FAIL fwd_count got=%0d exp=1", branch_count); end
  endtask

  task automatic test_squash();
    apply_reset();
    step(4'd9, 1, 0, 0, 0);
    nchk++; if (obs_br !== 1'b1) begin nerr++; $display("FAIL sq_bnz got=%b exp=1", obs_br); end
    step(4'd6, 1, 0, 0, 1);
    nchk++; if (obs_kill !== 1'b1 || flag_z !== 1'b0) begin nerr++; $display("FAIL sq_sub kill=%b z=%b exp kill=1 z=0", obs_kill, flag_z); end
    step(4'd4, 1, 0, 0, 1);
    nchk++; if (obs_kill !== 1'b1 || flag_z !== 1'b0) begin nerr++; $display("FAIL sq_add kill=%b z=%b exp kill=1 z=0", obs_kill, flag_z); end
    step(4'd8, 1, 0, 0, 1);
    nchk++; if (obs_kill !== 1'b0 || flag_z !== 1'b1) begin nerr++; $display("FAIL sq_nand kill=%b z=%b exp kill=0 z=1", obs_kill, flag_z); end
  endtask

  task automatic test_bubble_stall();
    apply_reset();
    step(4'd13, 1, 0, 0, 0);
    nchk++; if (obs_br !== 1'b1) begin nerr++; $display("FAIL bs_bpz got=%b exp=1", obs_br); end
    step(4'd10, 0, 0, 0, 0);
    step(4'd10, 0, 0, 0, 0);
    step(4'd4, 1, 1, 0, 1);
    step(4'd4, 1, 0, 0, 1);
    nchk++; if (obs_kill !== 1'b1) begin nerr++; $display("FAIL bs_first_kill got=%b exp=1", obs_kill); end
    step(4'd6, 1, 0, 0, 1);
    nchk++; if (obs_kill !== 1'b1) begin nerr++; $display("FAIL bs_second_kill got=%b exp=1", obs_kill); end
    nchk++; if (branch_count !== 8'd1 || flag_z !== 1'b0) begin nerr++; $display("FAIL bs_state count=%0d z=%b exp count=1 z=0", branch_count, flag_z); end
    step(4'd10, 1, 0, 0, 0);
    nchk++; if (obs_kill !== 1'b0) begin nerr++; $display("FAIL bs_window_closed got=%b exp=0", obs_kill); end
  endtask

  task automatic test_killed_branch();
    apply_reset();
    step(4'd4, 1, 0, 0, 1);
    step(4'd5, 1, 0, 0, 0);
    step(4'd5, 1, 0, 0, 0);
    nchk++; if (obs_br !== 1'b0 || obs_kill !== 1'b1) begin nerr++; $display("FAIL kb_second br=%b kill=%b exp br=0 kill=1", obs_br, obs_kill); end
    nchk++; if (branch_count !== 8'd1) begin nerr++; $display("FAIL kb_count got=%0d exp=1", branch_count); end
  endtask

  task automatic test_halt();
    apply_reset();
    step(4'd4, 1, 0, 0, 1);
    step(4'd1, 1, 0, 0, 0);
    nchk++; if (halted !== 1'b1) begin nerr++; $display("FAIL halt_set got=%b exp=1", halted); end
    step(4'd5, 1, 0, 0, 0);
    nchk++; if (obs_br !== 1'b0 || obs_kill !== 1'b1) begin nerr++; $display("FAIL halt_bz br=%b kill=%b exp br=0 kill=1", obs_br, obs_kill); end
    step(4'd4, 1, 0, 1, 0);
    nchk++; if (flag_n !== 1'b0 || flag_z !== 1'b1) begin nerr++; $display("FAIL halt_frozen n=%b z=%b exp n=0 z=1", flag_n, flag_z); end
    #2 reset = 1'b1;
    #1;
    nchk++; if (halted !== 1'b0 || flag_z !== 1'b0 || flag_n !== 1'b0) begin nerr++; $display("FAIL halt_async_reset h=%b n=%b z=%b exp 0 0 0", halted, flag_n, flag_z); end
    @(negedge clock);
    reset = 1'b0; ex_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_decode_corner();
    apply_reset();
    step(4'd13, 1, 0, 0, 0);
    nchk++; if (obs_br !== 1'b1) begin nerr++; $display("FAIL dec_op13 got=%b exp=1", obs_br); end
    step(4'd10, 1, 0, 0, 0);
    step(4'd10, 1, 0, 0, 0);
    step(4'd15, 1, 0, 1, 0);
    nchk++; if (obs_br !== 1'b0 || flag_n !== 1'b1 || flag_z !== 1'b0) begin nerr++; $display("FAIL dec_op15 br=%b n=%b z=%b exp 0 1 0", obs_br, flag_n, flag_z); end
    step(4'd12, 1, 0, 0, 1);
    nchk++; if (flag_n !== 1'b1 || flag_z !== 1'b0) begin nerr++; $display("FAIL dec_op12 n=%b z=%b exp 1 0", flag_n, flag_z); end
  endtask

  task automatic test_saturation();
    int misses;
    misses = 0;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      step(4'd13, 1, 0, 0, 0);
      if (obs_br !== 1'b1) misses++;
      for (int k = 0; k < SQ; k++) step(4'd10, 1, 0, 0, 0);
      if (i == 100) begin
        nchk++; if (branch_count !== 8'd101) begin nerr++; $display("FAIL sat_mid got=%0d exp=101", branch_count); end
      end
    end
    nchk++; if (misses != 0) begin nerr++; $display("FAIL sat_taken misses=%0d exp=0", misses); end
    nchk++; if (branch_count !== 8'd255) begin nerr++; $display("FAIL sat_count got=%0d exp=255", branch_count); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic v, s;
    int bad;
    bad = 0;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      if (m_halt && $urandom_range(0, 5) == 0) apply_reset();
      op = 4'($urandom_range(0, 15));
      if (op == 4'd1 && $urandom_range(0, 3) != 0) op = 4'd10;
      v = ($urandom_range(0, 9) < 8);
      s = ($urandom_range(0, 4) == 0);
      step(op, v, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      nchk++;
      if (obs_br !== p_br || obs_kill !== p_kill || flag_n !== m_fn || flag_z !== m_fz ||
          halted !== m_halt || branch_count !== CW'(m_cnt)) begin
        nerr++;
        if (bad < 10)
          $display("FAIL rand cyc=%0d op=%0d got br=%b kill=%b n=%b z=%b h=%b cnt=%0d exp br=%b kill=%b n=%b z=%b h=%b cnt=%0d",
                   i, op, obs_br, obs_kill, flag_n, flag_z, halted, branch_count,
                   p_br, p_kill, m_fn, m_fz, m_halt, m_cnt);
        bad++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    cls = '{0, 3, 0, 1, 1, 2, 1, 1, 1, 2, 0, 1, 0, 2, 0, 1};
    model_reset();
    test_reset();
    test_forwarding();
    test_squash();
    test_bubble_stall();
    test_killed_branch();
    test_halt();
    test_decode_corner();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/control_branch.md
Name: control_branch

Overview:
Execute-stage branch-resolution control for the pipelined processor; it produces the `branch` signal consumed by the fetch-stage control, which drives PC select.
- Holds the architectural N/Z condition flags.
- Decides BZ/BNZ/BPZ outcomes.
- Squashes the younger in-flight instructions after a taken branch.
- Latches STOP as a sticky halt.
- Keeps a saturating taken-branch counter for debug.

Parameters:
SQUASH_DEPTH, 2, number of younger instructions (IR1/IR2 slots) killed after a taken branch; legal range 1..3.
CNT_WIDTH, 8, width of the taken-branch counter.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
ex_opcode  input  4  opcode of the instruction in execute (IR3[3:0]).
ex_valid  input  1  execute slot holds a real instruction (0 = bubble).
ex_stall  input  1  pipeline held this cycle; no state change.
alu_n  input  1  ALU result negative, for the execute instruction.
alu_z  input  1  ALU result zero, for the execute instruction.
branch  output  1  take branch now; to fetch pc_sel (combinational).
ex_kill  output  1  execute instruction is squashed; suppress register-file/memory writes.
flag_n  output  1  registered N flag.
flag_z  output  1  registered Z flag.
halted  output  1  sticky, set by an executed STOP.
branch_count  output  CNT_WIDTH  saturating count of taken branches.

Behaviour:
- Reset (asynchronous):
  - flag_n=0, flag_z=0, halted=0, branch_count=0, internal squash_cnt=0.
  - branch=0 and ex_kill=0 while reset is high.
- Opcode decode:
  - ALU class: add=4, sub=6, nand=8, plus ex_opcode[2:0]==3 (shift) or ex_opcode[2:0]==7 (ori).
  - Branch class: bz=5, bnz=9, bpz=13.
  - Others: stop=1, load=0, store=2, nop=10.
  - The 4-bit exact matches take priority over the 3-bit matches; e.g. 13 is bpz, not ori.
- Effective valid (eff) = ex_valid & ~halted & (squash_cnt==0). ex_kill = ex_valid & ~eff.
- Branch condition (combinational, uses the registered flags):
  - bz: flag_z==1. bnz: flag_z==0. bpz: flag_n==0.
  - branch = eff & ~ex_stall & branch-class & condition. Zero-cycle latency; fetch loads the target at the same edge.
- Clocked updates, rising edge, all skipped when ex_stall=1:
  - Flags: on an eff ALU-class instruction, flag_n<=alu_n and flag_z<=alu_z; otherwise hold. Load/store/branch/nop never touch the flags.
  - Forwarding: a branch directly behind an ALU op sees the new flags, because the flags register at the end of the ALU op's execute cycle.
  - Squash: if branch=1, squash_cnt<=SQUASH_DEPTH. Else if squash_cnt!=0 and ex_valid=1, squash_cnt decrements. Bubbles (ex_valid=0) do not consume the squash budget.
  - Halt: on an eff STOP, halted<=1. It clears only on reset.
  - Counter: branch_count increments on each branch=1 edge and saturates at all-ones.
- Boundary conditions:
  - A branch, ALU op or STOP arriving inside the squash window is killed: no flag change, no branch, no halt.
  - A stall during the squash window holds squash_cnt.
  - Once halted, all later instructions are killed, branch stays 0 and the flags are frozen.
  - Reset mid-squash clears the window immediately.

Decomposition:
- Shared package cpu_defs:
  - Opcode constants (i_load, i_stop, i_store, i_add, i_bz, i_subtract, i_nand, i_bnz, i_nop, i_bpz as 4-bit; i_shift, i_ori as 3-bit).
  - Opcode-class decode functions (is_alu, is_branch).
  - Also used by control_fetch.
- One natural sub-module, branch_cond_eval: combinational (opcode, flag_n, flag_z) -> take.

Test Plan:
- Flag/branch forwarding:
  - Stimulus: reset; then add with alu_z=1, alu_n=0, followed next cycle by bz.
  - Required: flag_z=1 after the add edge; branch=1 during the bz cycle; branch_count=1.
- Squash window:
  - Stimulus: bnz taken with flag_z=0, then three valid instructions sub, add, nand, each with alu_z=1.
  - Required: ex_kill=1 for sub and add, flag_z stays 0; nand executes, ex_kill=0, flag_z=1.
- Bubbles and stalls in the window:
  - Stimulus: taken bpz, then ex_valid=0 for 2 cycles, then ex_stall=1 for 1 cycle with a valid add, then 2 valid instructions.
  - Required: both of the final 2 instructions killed; branch_count=1.
- Killed branch:
  - Stimulus: taken bz immediately followed by another bz with flag_z=1.
  - Required: the second bz has branch=0, ex_kill=1; branch_count=1.
- Halt:
  - Stimulus: stop with ex_valid=1, then bz with flag_z=1.
  - Required: halted=1 from the next edge; branch=0 and ex_kill=1 thereafter; reset asserted asynchronously mid-cycle returns halted=0 and flags=0 immediately.
- Decode corner and saturation:
  - Stimulus: opcode 13 with flag_n=0; opcode 15 (ori) with alu_n=1; 300 taken branches with CNT_WIDTH=8, squash respected.
  - Required: opcode 13 treated as a branch (branch=1); opcode 15 updates flag_n=1 with no branch; branch_count saturates at 255.
